// File: rtl/sub_seq_pkg.sv
// Shared definitions for the sequential slice subtractor.
// Holds the FSM state encoding and the slice width.
package sub_seq_pkg;

   localparam int unsigned SLICE_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sub_slice_4.sv
// Combinational 4-bit slice of a - b, computed as a + ~b + cin with lookahead.
// Ports:
//   a4   : minuend slice
//   nb4  : inverted subtrahend slice
//   cin  : carry into bit 0 (1 = no borrow in)
//   d4   : difference slice
//   cout : carry out of bit 3 (0 = borrow out)
//   c3   : carry into bit 3, used for signed overflow on the top slice
module sub_slice_4
   import sub_seq_pkg::*;
(
   input  logic [SLICE_W-1:0] a4,
   input  logic [SLICE_W-1:0] nb4,
   input  logic               cin,
   output logic [SLICE_W-1:0] d4,
   output logic               cout,
   output logic               c3
);

   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [SLICE_W:0]   c;

   assign g = a4 & nb4;
   assign p = a4 ^ nb4;

   // Flattened lookahead carries
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign d4   = p ^ c[SLICE_W-1:0];
   assign cout = c[4];
   assign c3   = c[3];

endmodule

// File: rtl/sub_seq_4.sv
// Multi-cycle WIDTH-bit subtractor: one 4-bit slice per clock, LSB slice first,
// with a registered carry chain between slices and valid/ready on both sides.
// Optional macro SUB_SEQ_OVF_EN adds the signed overflow output ovf.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b                 : minuend, subtrahend
//   out_valid / out_ready: result handshake
//   diff                 : a - b mod 2^WIDTH
//   borrow               : unsigned a < b
//   ovf                  : signed overflow (SUB_SEQ_OVF_EN only)
module sub_seq_4
   import sub_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SUB_SEQ_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NSLICE = WIDTH / SLICE_W;
   localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_nb_q, op_nb_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_q, borrow_d;
   logic               out_valid_q, out_valid_d;
`ifdef SUB_SEQ_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   logic [SLICE_W-1:0] sl_a, sl_nb, sl_d;
   logic               sl_cout, sl_c3;

   // Select the operand slice addressed by cnt
   always_comb begin
      sl_a  = '0;
      sl_nb = '0;
      for (int unsigned i = 0; i < NSLICE; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            sl_a  = op_a_q[i*SLICE_W +: SLICE_W];
            sl_nb = op_nb_q[i*SLICE_W +: SLICE_W];
         end
      end
   end

   sub_slice_4 u_slice (
      .a4   (sl_a),
      .nb4  (sl_nb),
      .cin  (carry_q),
      .d4   (sl_d),
      .cout (sl_cout),
      .c3   (sl_c3)
   );

`ifndef SUB_SEQ_OVF_EN
   logic unused_c3;
   assign unused_c3 = sl_c3;
`endif

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      op_a_d      = op_a_q;
      op_nb_d     = op_nb_q;
      diff_d      = diff_q;
      borrow_d    = borrow_q;
      out_valid_d = out_valid_q;
`ifdef SUB_SEQ_OVF_EN
      ovf_d       = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_a_d  = a;
               op_nb_d = ~b;
               carry_d = 1'b1;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            for (int unsigned i = 0; i < NSLICE; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  diff_d[i*SLICE_W +: SLICE_W] = sl_d;
               end
            end
            carry_d = sl_cout;
            if (cnt_q == LAST) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               borrow_d    = ~sl_cout;
`ifdef SUB_SEQ_OVF_EN
               ovf_d       = sl_c3 ^ sl_cout;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b1;
         op_a_q      <= '0;
         op_nb_q     <= '0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef SUB_SEQ_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         op_a_q      <= op_a_d;
         op_nb_q     <= op_nb_d;
         diff_q      <= diff_d;
         borrow_q    <= borrow_d;
         out_valid_q <= out_valid_d;
`ifdef SUB_SEQ_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign borrow    = borrow_q;
`ifdef SUB_SEQ_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_sub_seq_4.sv
// Directed self-checking bench for sub_seq_4 (WIDTH=16).
module tb_sub_seq_4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        borrow;
`ifdef SUB_SEQ_OVF_EN
   logic        ovf;
`endif

   int chk_cnt  = 0;
   int pass_cnt = 0;

   sub_seq_4 #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow)
`ifdef SUB_SEQ_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Present operands for one accept edge; returns on the negedge after it
   task automatic accept(input logic [15:0] av, input logic [15:0] bv);
      @(negedge clk);
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count negedges until out_valid is seen (bounded)
   task automatic wait_out_valid(output int cycles);
      cycles = 0;
      for (int k = 0; k < 20; k++) begin
         if (out_valid) break;
         @(negedge clk);
         cycles++;
      end
   endtask

   // One consume cycle with out_ready high
   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      #12;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else pass_cnt++;
      chk_cnt++; if (diff !== 16'h0000) $display("FAIL reset_diff: got %h exp 0000", diff); else pass_cnt++;
      chk_cnt++; if (borrow !== 1'b0) $display("FAIL reset_borrow: got %b exp 0", borrow); else pass_cnt++;
`ifdef SUB_SEQ_OVF_EN
      chk_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b exp 0", ovf); else pass_cnt++;
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int cyc;
      accept(16'h1234, 16'h0234);
      wait_out_valid(cyc);
      chk_cnt++; if (cyc !== 4) $display("FAIL basic_latency: got %0d exp 4", cyc); else pass_cnt++;
      chk_cnt++; if (diff !== 16'h1000) $display("FAIL basic_diff: got %h exp 1000", diff); else pass_cnt++;
      chk_cnt++; if (borrow !== 1'b0) $display("FAIL basic_borrow: got %b exp 0", borrow); else pass_cnt++;
      consume();
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_consumed: got %b exp 0", out_valid); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_ready_again: got %b exp 1", in_ready); else pass_cnt++;

      accept(16'h0000, 16'h0001);
      wait_out_valid(cyc);
      chk_cnt++; if (diff !== 16'hFFFF) $display("FAIL underflow_diff: got %h exp ffff", diff); else pass_cnt++;
      chk_cnt++; if (borrow !== 1'b1) $display("FAIL underflow_borrow: got %b exp 1", borrow); else pass_cnt++;
`ifdef SUB_SEQ_OVF_EN
      chk_cnt++; if (ovf !== 1'b0) $display("FAIL underflow_ovf: got %b exp 0", ovf); else pass_cnt++;
`endif
      consume();

      accept(16'h5A5A, 16'h5A5A);
      wait_out_valid(cyc);
      chk_cnt++; if (diff !== 16'h0000) $display("FAIL equal_diff: got %h exp 0000", diff); else pass_cnt++;
      chk_cnt++; if (borrow !== 1'b0) $display("FAIL equal_borrow: got %b exp 0", borrow); else pass_cnt++;
      consume();

      accept(16'h0000, 16'h0000);
      wait_out_valid(cyc);
      chk_cnt++; if (diff !== 16'h0000) $display("FAIL zero_diff: got %h exp 0000", diff); else pass_cnt++;
      chk_cnt++; if (borrow !== 1'b0) $display("FAIL zero_borrow: got %b exp 0", borrow); else pass_cnt++;
      consume();
   endtask

   task automatic test_ovf();
      int cyc;
      accept(16'h8000, 16'h0001);
      wait_out_valid(cyc);
      chk_cnt++; if (diff !== 16'h7FFF) $display("FAIL ovf_diff: got %h exp 7fff", diff); else pass_cnt++;
      chk_cnt++; if (borrow !== 1'b0) $display("FAIL ovf_borrow: got %b exp 0", borrow); else pass_cnt++;
`ifdef SUB_SEQ_OVF_EN
      chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", ovf); else pass_cnt++;
`endif
      consume();

      accept(16'h0005, 16'h0003);
      wait_out_valid(cyc);
      chk_cnt++; if (diff !== 16'h0002) $display("FAIL small_diff: got %h exp 0002", diff); else pass_cnt++;
      chk_cnt++; if (borrow !== 1'b0) $display("FAIL small_borrow: got %b exp 0", borrow); else pass_cnt++;
`ifdef SUB_SEQ_OVF_EN
      chk_cnt++; if (ovf !== 1'b0) $display("FAIL small_ovf: got %b exp 0", ovf); else pass_cnt++;
`endif
      consume();
   endtask

   task automatic test_stall();
      int cyc;
      accept(16'hABCD, 16'h0BCD);
      wait_out_valid(cyc);
      chk_cnt++; if (cyc !== 4) $display("FAIL stall_latency: got %0d exp 4", cyc); else pass_cnt++;
      // Competing operands while the result is held
      a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk_cnt++; if (diff !== 16'hA000) $display("FAIL stall_diff[%0d]: got %h exp a000", k, diff); else pass_cnt++;
         chk_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b exp 1", k, out_valid); else pass_cnt++;
         chk_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b exp 0", k, in_ready); else pass_cnt++;
      end
      chk_cnt++; if (borrow !== 1'b0) $display("FAIL stall_borrow: got %b exp 0", borrow); else pass_cnt++;
      // Consume edge must not also accept
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_consumed: got %b exp 0", out_valid); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_no_same_cycle_accept: got %b exp 1", in_ready); else pass_cnt++;
      @(negedge clk);
      in_valid = 1'b0;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_next_accept: got %b exp 0", in_ready); else pass_cnt++;
      wait_out_valid(cyc);
      chk_cnt++; if (cyc !== 4) $display("FAIL stall_second_latency: got %0d exp 4", cyc); else pass_cnt++;
      chk_cnt++; if (diff !== 16'h0000) $display("FAIL stall_second_diff: got %h exp 0000", diff); else pass_cnt++;
      consume();
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      accept(16'h1234, 16'h0001);
      @(negedge clk);
      @(negedge clk);
      // Now at slice index 2 with lower slices of diff already written
      rst_n = 1'b0;
      #1;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid: got %b exp 0", out_valid); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b exp 1", in_ready); else pass_cnt++;
      chk_cnt++; if (diff !== 16'h0000) $display("FAIL abort_diff: got %h exp 0000", diff); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      accept(16'h0010, 16'h0001);
      wait_out_valid(cyc);
      chk_cnt++; if (cyc !== 4) $display("FAIL post_abort_latency: got %0d exp 4", cyc); else pass_cnt++;
      chk_cnt++; if (diff !== 16'h000F) $display("FAIL post_abort_diff: got %h exp 000f", diff); else pass_cnt++;
      chk_cnt++; if (borrow !== 1'b0) $display("FAIL post_abort_borrow: got %b exp 0", borrow); else pass_cnt++;
      consume();
   endtask

   task automatic test_back_to_back();
      int cyc;
      out_ready = 1'b1;
      @(negedge clk);
      a = 16'h00FF; b = 16'h00F0; in_valid = 1'b1;
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF;
      wait_out_valid(cyc);
      chk_cnt++; if (cyc !== 4) $display("FAIL b2b_first_latency: got %0d exp 4", cyc); else pass_cnt++;
      chk_cnt++; if (diff !== 16'h000F) $display("FAIL b2b_first_diff: got %h exp 000f", diff); else pass_cnt++;
      chk_cnt++; if (borrow !== 1'b0) $display("FAIL b2b_first_borrow: got %b exp 0", borrow); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_idle_after_consume: got %b exp 1", in_ready); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_second_accept: got %b exp 0", in_ready); else pass_cnt++;
      in_valid = 1'b0;
      out_ready = 1'b0;
      wait_out_valid(cyc);
      chk_cnt++; if (cyc !== 4) $display("FAIL b2b_second_latency: got %0d exp 4", cyc); else pass_cnt++;
      chk_cnt++; if (diff !== 16'h0000) $display("FAIL b2b_second_diff: got %h exp 0000", diff); else pass_cnt++;
      chk_cnt++; if (borrow !== 1'b0) $display("FAIL b2b_second_borrow: got %b exp 0", borrow); else pass_cnt++;
      consume();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ovf();
      test_stall();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/sub_seq_4.md
Name: sub_seq_4

Overview:
- Multi-cycle WIDTH-bit subtractor (diff = a - b), the inverse of the team's combinational 4-bit CLA adder.
- Processes one 4-bit slice per clock, least-significant slice first, with a registered borrow chain between slices.
- Valid/ready handshake on both input and output.
- Sits in the arithmetic datapath wherever area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, number of 4-bit slices; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands a/b present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend (unsigned or two's complement).
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow  output  1  1 when unsigned a < b.
- ovf  output  1  signed overflow; present only with SUB_SEQ_OVF_EN.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. No synchronous reset.
- States: IDLE, RUN, DONE.
- Reset state:
  - state=IDLE, slice counter=0, carry register=1.
  - Operand registers=0, diff=0, borrow=0, ovf=0, out_valid=0.
  - in_ready=1, because in_ready is combinational: (state==IDLE).
- IDLE:
  - On in_valid && in_ready, latch a into op_a and ~b into op_nb.
  - Set carry=1, cnt=0, go to RUN.
- RUN:
  - Each edge computes slice cnt: {c_out, d4} = op_a[4cnt+3:4cnt] + op_nb[4cnt+3:4cnt] + carry.
  - Write d4 into diff[4cnt+3:4cnt] and set carry=c_out.
  - When cnt==NSLICE-1, go to DONE. Otherwise cnt++.
- DONE:
  - out_valid=1; borrow=~carry.
  - diff, borrow and ovf stay stable while out_valid && !out_ready.
  - On out_ready, go to IDLE. out_valid deasserts on the same edge.
- Latency: out_valid rises NSLICE cycles after the accept edge (4 for WIDTH=16).
- Throughput: one result per NSLICE+2 cycles.
- in_ready=0 in RUN and DONE. Input arriving then is ignored, not queued.
- No accept in the same cycle as result consumption. The next accept is possible on the following cycle.
- Operand registers are captured only at accept. Input changes during RUN have no effect.
- diff retains its last value after consumption. It is meaningful only while out_valid=1.
- Asserting rst_n low at any point (mid-RUN, or DONE with a pending result) aborts the operation and restores all reset values. The pending result is lost.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - No intermediate exceeds 5 bits per slice.
  - borrow is unsigned; ovf is signed.
- Boundary cases:
  - a==b gives diff=0, borrow=0.
  - a=0, b=0 gives diff=0, borrow=0.
  - WIDTH=4 means a single RUN cycle.

Optional Feature:
- Macro: SUB_SEQ_OVF_EN.
- When defined:
  - ovf port exists.
  - In the last RUN cycle, ovf is registered as (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), computed inside the top slice.
  - ovf obeys the same stability and reset rules as borrow.
- When undefined:
  - Port absent and no overflow logic is generated.
  - All other behaviour is identical.

Decomposition:
- Package sub_seq_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - SLICE_W=4.
- Sub-module sub_slice_4: purely combinational 4-bit slice.
  - Inputs: a4, nb4, cin.
  - Outputs: d4, cout, c3; c3 is the carry into bit 3, used for ovf.
  - Internally uses generate/propagate lookahead.
  - Instantiated once in sub_seq_4, muxed by cnt.

Test Plan:
- 0x1234 - 0x0234, out_ready=1 → out_valid 4 cycles after accept; diff=0x1000, borrow=0.
- 0x0000 - 0x0001 → diff=0xFFFF, borrow=1; borrow propagates through all 4 slices.
- 0x8000 - 0x0001 with SUB_SEQ_OVF_EN → diff=0x7FFF, borrow=0, ovf=1. Also 0x0005 - 0x0003 → diff=0x0002, ovf=0.
- 0xABCD - 0x0BCD with out_ready held low 5 cycles → diff=0xA000 stable, out_valid=1, in_ready=0. A concurrent in_valid with 0x1111/0x1111 is ignored. The first result is delivered; the next accept occurs only after consumption.
- rst_n low 1 cycle during RUN at cnt=2 → out_valid=0, in_ready=1, diff=0 immediately (asynchronous). A following 0x0010 - 0x0001 yields diff=0x000F.
- Back-to-back: out_ready=1, in_valid=1 continuously with 0x00FF - 0x00F0 then 0xFFFF - 0xFFFF → results 0x000F then 0x0000, borrow=0 both; the second accept occurs one cycle after the first consumption.
